mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the multi-cycle datapath.
- Sits directly downstream of the register file: `a`/`b` are driven from the two register-file read-data outputs.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers, one result bit per clock.
- The control FSM stalls on `busy` and uses the `done` pulse to advance.

Parameters:
- WIDTH, 32, operand width; `hi`/`lo` are WIDTH bits each, the product is 2*WIDTH.
- ITER, WIDTH, number of iteration cycles; always equal to WIDTH, not independently settable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request operation; sampled on a rising edge when busy=0.
- op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend), from register-file read port 1.
- b  input  WIDTH  rt operand (multiplier / divisor), from register-file read port 2.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; hi/lo hold the new result from this cycle on.
- hi  output  WIDTH  HI register: product[63:32] or remainder.
- lo  output  WIDTH  LO register: product[31:0] or quotient.
- div_by_zero  output  1  valid with done; high if DIV/DIVU had b==0.

Behaviour:
- Reset (rst=1, asynchronous, any state): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0. An in-flight operation is abandoned; no done is produced.
- FSM states: IDLE, RUN, FIX.
  - IDLE: when start=1 at edge k:
    - latch op, |a|, |b| (magnitudes for signed ops, raw values for unsigned);
    - latch sign_a and sign_b;
    - latch dz = (op[1] && b==0);
    - clear the accumulator, counter=0, busy=1, go to RUN.
  - RUN: one iteration per edge, edges k+1..k+32; counter increments each edge; after the 32nd iteration go to FIX.
    - Multiply: shift-add on the 64-bit {acc, multiplier}, unsigned magnitudes.
    - Divide: restoring division, one quotient bit per cycle, unsigned magnitudes.
  - FIX, at edge k+33:
    - apply the sign correction, write hi/lo, done=1 for exactly one cycle, busy=0, return to IDLE.
- Signed sign rules:
  - MULT: 64-bit product negated if sign_a^sign_b.
  - DIV: quotient negated if sign_a^sign_b; remainder takes the sign of a.
- Latency: start at edge k gives done high from edge k+33 to k+34. busy is high from k to k+33.
- hi/lo change only at the FIX edge or on reset; they hold between operations.
- start while busy=1: ignored. No queueing; op/a/b are not resampled.
- start in the same cycle done=1: accepted (state is IDLE). The new operation begins; done still deasserts on the next edge.
- Divide by zero (dz=1): full latency still applies. At FIX: lo=32'hFFFFFFFF, hi=a as latched (original signed value, not magnitude), div_by_zero=1 for the done cycle. Otherwise div_by_zero=0.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0. This is the natural result of magnitude division followed by negation; no special case.
- MULT/MULTU never set div_by_zero.
- Operands a/b may change after the start edge without effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge k -> busy=1 for 33 cycles; done at k+33; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; a second MULTU 5*6 started in the done cycle -> hi=0, lo=30, done 33 cycles later.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
- DIVU a=100 b=0 -> done at k+33 with div_by_zero=1, lo=0xFFFFFFFF, hi=100. A following MULTU 2*2 -> div_by_zero=0, lo=4.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start MULTU 3*4; pulse start with different operands at k+5 -> ignored, result hi=0, lo=12. Then start again and assert rst mid-cycle at k+10 -> busy=0, hi=0, lo=0 immediately (asynchronous), and no done ever appears.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide, one bit per clock,
// with sign fix-up on unsigned magnitudes before the HI/LO write.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned ITER = WIDTH;
    localparam int unsigned CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic             sign_a_q, sign_b_q, dz_q;
    logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
    logic [CW-1:0]    cnt_q;

    logic             sign_a_in, sign_b_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, rem_sh, diff;
    logic [WIDTH-1:0] acc_n, mq_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

    // op[0]=1 selects the unsigned variants, which never carry a sign.
    always_comb begin
        sign_a_in = ~op[0] & a[WIDTH-1];
        sign_b_in = ~op[0] & b[WIDTH-1];
        mag_a     = sign_a_in ? -a : a;
        mag_b     = sign_b_in ? -b : b;
    end

    // mq_q holds the multiplier (shifting out) or the dividend/quotient (shifting through).
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_q, mq_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd_q};
        if (op_q[1]) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                mq_n  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                mq_n  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = {acc_q, mq_q};
        if (sign_a_q ^ sign_b_q) prod = -prod;
        quo = mq_q;
        if (sign_a_q ^ sign_b_q) quo = -quo;
        rem = acc_q;
        if (sign_a_q) rem = -rem;
        // Divide by zero leaves rem == a naturally; only the quotient needs forcing.
        if (dz_q) quo = '1;
        res_hi = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = op_q[1] ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            dz_q        <= 1'b0;
            acc_q       <= '0;
            mq_q        <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q     <= op;
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        dz_q     <= op[1] && (b == '0);
                        opnd_q   <= op[1] ? mag_b : mag_a;
                        mq_q     <= op[1] ? mag_a : mag_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_n;
                    mq_q  <= mq_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) state_q <= StFix;
                end
                StFix: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: arithmetic reference model checked every cycle, plus directed
// vectors with hand-computed HI/LO and latency expectations.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain 64-bit arithmetic.
    function automatic void calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sx, sy;
        logic [63:0] p;
        sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
        sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
        z  = 1'b0;
        if (!o[1]) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'd0) begin
            z = 1'b1;
            l = 32'hFFFF_FFFF;
            h = x;
        end else begin
            p = sx / sy;
            l = p[31:0];
            p = sx % sy;
            h = p[31:0];
        end
    endfunction

    logic        m_busy, m_done, m_dz, r_dz;
    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_left = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_hi = r_hi; m_lo = r_lo; m_dz = r_dz;
                end
            end else if (start) begin
                calc(op, a, b, r_hi, r_lo, r_dz);
                m_left = 33;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Called at a negedge; the start is sampled on the following posedge.
    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input string nm, input int exp_lat, input logic [31:0] eh,
                             input logic [31:0] el, input logic ez);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(exp_lat));
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        chk({nm, " dz"}, 64'(div_by_zero), 64'(ez));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 0; b = 0;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        do_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);

        do_start(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult -3*7", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        do_start(2'b01, 32'd5, 32'd6);
        chk("done drops after back-to-back start", 64'(done), 64'd0);
        wait_done("multu 5*6", 33, 32'd0, 32'd30, 1'b0);
        @(negedge clk);

        do_start(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_start(2'b11, 32'd100, 32'd7);
        wait_done("divu 100/7", 33, 32'd2, 32'd14, 1'b0);
        do_start(2'b11, 32'd100, 32'd0);
        wait_done("divu by zero", 33, 32'd100, 32'hFFFF_FFFF, 1'b1);
        do_start(2'b01, 32'd2, 32'd2);
        wait_done("multu 2*2", 33, 32'd0, 32'd4, 1'b0);
        do_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div overflow", 33, 32'd0, 32'h8000_0000, 1'b0);
        do_start(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done("div -7 by zero", 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);

        // Second start mid-operation must be ignored.
        do_start(2'b01, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        do_start(2'b00, 32'd9, 32'd9);
        wait_done("multu 3*4 ignore", 28, 32'd0, 32'd12, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        do_start(2'b01, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("no done after reset", 64'(seen), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
